vis_axis_packer: RTL
====================

VIS_AXIS_PACKER -- requirements
Module: vis_axis_packer

Interface
REQ-001 SHALL have parameter MAGIC, default 16'hA55A, the frame-header sync word.
REQ-002 SHALL have parameter CBITS, default 16, the width of the sequence and word counters; legal range 8..16.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port s_tvalid_i, input, 1 bit: visibility word valid, from the correlator bus output.
REQ-006 SHALL have port s_tready_o, output, 1 bit: ready to accept a visibility word.
REQ-007 SHALL have port s_tlast_i, input, 1 bit: marks the final visibility word of a correlator frame.
REQ-008 SHALL have port s_revis_i, input, 32 bits: real part of the visibility.
REQ-009 SHALL have port s_imvis_i, input, 32 bits: imaginary part of the visibility.
REQ-010 SHALL have port m_tvalid_o, output, 1 bit: byte-stream valid, to the USB bulk-IN AXIS sink.
REQ-011 SHALL have port m_tready_i, input, 1 bit: byte-stream ready.
REQ-012 SHALL have port m_tlast_o, output, 1 bit: marks the final byte of a packed frame.
REQ-013 SHALL have port m_tdata_o, output, 8 bits: stream byte.
REQ-014 SHALL have port busy_o, output, 1 bit: high while a frame is in progress, i.e. the state is not IDLE.

Function
REQ-015 SHALL define an input transfer as s_tvalid_i && s_tready_o, and an output transfer as m_tvalid_o && m_tready_i, both sampled at a rising aclk edge.
REQ-016 SHALL hold one visibility word in a 64-bit buffer with full flag and last flag; s_tready_o SHALL be registered and equal to ~full.
REQ-017 SHALL use a state machine with states IDLE, HEAD, DATA and TAIL.
REQ-018 IDLE -> HEAD on the cycle after the buffer becomes full.
REQ-019 HEAD SHALL emit 4 bytes: MAGIC[15:8], MAGIC[7:0], seq[15:8], seq[7:0]; seq is zero-extended to 16 bits when CBITS<16.
REQ-020 HEAD -> DATA after the 4th byte transfers.
REQ-021 DATA SHALL emit 8 bytes per word in this order: revis[31:24], revis[23:16], revis[15:8], revis[7:0], imvis[31:24], imvis[23:16], imvis[15:8], imvis[7:0].
REQ-022 The 8th byte transfer of a word SHALL clear full, so s_tready_o rises on the next cycle.
REQ-023 After the 8th byte, if that word's last flag was set, DATA -> TAIL.
REQ-024 After the 8th byte, if last was clear, the block SHALL stay in DATA; m_tvalid_o drops until the next word is buffered.
REQ-025 TAIL SHALL emit 2 bytes: wcount[15:8], wcount[7:0].
REQ-026 m_tlast_o SHALL be 1 only on the 2nd TAIL byte.
REQ-027 After the 2nd TAIL byte transfers, the block SHALL go to IDLE, increment seq (modulo 2^CBITS, wrapping from all-ones to 0) and clear wcount.
REQ-028 wcount SHALL count words accepted in the current frame and saturate at 2^CBITS-1.
REQ-029 Output SHALL be registered: first HEAD byte valid 1 cycle after the IDLE->HEAD transition; one byte per cycle while m_tready_i stays high.
REQ-030 While m_tvalid_o=1 and m_tready_i=0, m_tdata_o and m_tlast_o SHALL hold stable, and m_tvalid_o SHALL NOT deassert.
REQ-031 An input transfer and the 8th-byte output transfer may occur on the same edge; the new word SHALL be captured and no byte lost or duplicated.
REQ-032 In DATA, a buffered word SHALL be accepted only after its predecessor's last byte.
REQ-033 No input word SHALL be accepted while in TAIL or HEAD after the buffer is full.

Reset
REQ-034 On aresetn=0, immediately and regardless of clock: state=IDLE, full=0, seq=0, wcount=0, s_tready_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=8'h00, busy_o=0.
REQ-035 One cycle after aresetn rises, s_tready_o SHALL be 1.
REQ-036 Reset mid-frame SHALL discard the partial frame; the next frame SHALL start with seq=0.

Verification
REQ-037 Single word re=32'h01020304, im=32'h05060708, last=1, m_tready_i=1 -> bytes A5 5A 00 00 01 02 03 04 05 06 07 08 00 01, tlast on the 14th byte only.
REQ-038 Three-word frame followed by a second one-word frame -> 1st frame has 30 bytes with wcount 00 03; 2nd frame header is A5 5A 00 01.
REQ-039 Random m_tready_i backpressure at 50% -> byte sequence identical to the no-stall case; data stable across every stall.
REQ-040 Back-to-back s_tvalid_i with last every 4th word -> no byte gaps inside a word; s_tready_o low while the buffer is full.
REQ-041 aresetn pulsed low during the 5th DATA byte -> outputs zero immediately; the next frame begins A5 5A 00 00.
REQ-042 CBITS=8 with 257 frames -> seq wraps FF -> 00; 300-word frame with CBITS=8 -> wcount 00 FF (saturated).

Source files
------------

// File: rtl/vis_axis_packer.sv
// rtl/vis_axis_packer.sv - packs correlator visibility words into a framed byte stream
// Frame layout: MAGIC(2) seq(2) { re(4) im(4) } x N  wcount(2), big-endian throughout.
module vis_axis_packer #(
    parameter logic [15:0] MAGIC = 16'hA55A,
    parameter int          CBITS = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_tvalid_i,
    output logic        s_tready_o,
    input  logic        s_tlast_i,
    input  logic [31:0] s_revis_i,
    input  logic [31:0] s_imvis_i,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        m_tlast_o,
    output logic [7:0]  m_tdata_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, HEAD, DATA, TAIL} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;

    logic [7:0][7:0]  buf_data;
    logic             buf_last;
    logic             full;
    logic             full_nxt;

    logic [CBITS-1:0] seq;
    logic [CBITS-1:0] wcount;
    logic [15:0]      seq16;
    logic [15:0]      wcount16;

    logic             accept;
    logic             xfer;
    logic             clear_buf;
    logic             tail_done;
    logic             load;
    logic             avail;
    logic [7:0]       byte_nxt;
    logic             last_nxt;

    assign accept    = s_tvalid_i && s_tready_o;
    assign xfer      = m_tvalid_o && m_tready_i;
    assign clear_buf = (state == DATA) && xfer && (idx == 3'd7);
    assign tail_done = (state == TAIL) && xfer && (idx == 3'd1);
    assign full_nxt  = accept || (full && !clear_buf);
    assign seq16     = 16'(seq);
    assign wcount16  = 16'(wcount);
    assign busy_o    = (state != IDLE);

    // state/idx name the byte position currently presented (or about to be);
    // the position only advances on an output transfer.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (full) begin
                    state_nxt = HEAD;
                    idx_nxt   = 3'd0;
                end
            end
            HEAD: begin
                if (xfer) begin
                    if (idx == 3'd3) begin
                        state_nxt = DATA;
                        idx_nxt   = 3'd0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (idx == 3'd7) begin
                        state_nxt = buf_last ? TAIL : DATA;
                        idx_nxt   = 3'd0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            TAIL: begin
                if (xfer) begin
                    if (idx == 3'd1) begin
                        state_nxt = IDLE;
                        idx_nxt   = 3'd0;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    // Byte for the next position; a data byte exists only while its word is
    // still buffered (the buffer just released by the 8th byte does not count).
    always_comb begin
        avail    = 1'b0;
        byte_nxt = 8'h00;
        last_nxt = 1'b0;
        case (state_nxt)
            HEAD: begin
                avail = 1'b1;
                case (idx_nxt[1:0])
                    2'd0:    byte_nxt = MAGIC[15:8];
                    2'd1:    byte_nxt = MAGIC[7:0];
                    2'd2:    byte_nxt = seq16[15:8];
                    default: byte_nxt = seq16[7:0];
                endcase
            end
            DATA: begin
                avail    = full && !clear_buf;
                byte_nxt = buf_data[3'd7 - idx_nxt];
            end
            TAIL: begin
                avail    = 1'b1;
                byte_nxt = idx_nxt[0] ? wcount16[7:0] : wcount16[15:8];
                last_nxt = idx_nxt[0];
            end
            default: begin
                avail = 1'b0;
            end
        endcase
    end

    // No load on the IDLE->HEAD edge itself, so the first header byte appears one cycle later.
    assign load = (state != IDLE) && (xfer || !m_tvalid_o);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            idx        <= 3'd0;
            buf_data   <= '0;
            buf_last   <= 1'b0;
            full       <= 1'b0;
            s_tready_o <= 1'b0;
            seq        <= '0;
            wcount     <= '0;
            m_tvalid_o <= 1'b0;
            m_tlast_o  <= 1'b0;
            m_tdata_o  <= 8'h00;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            full       <= full_nxt;
            s_tready_o <= !full_nxt;

            if (accept) begin
                buf_data <= {s_revis_i, s_imvis_i};
                buf_last <= s_tlast_i;
            end

            if (load) begin
                m_tvalid_o <= avail;
                if (avail) begin
                    m_tdata_o <= byte_nxt;
                    m_tlast_o <= last_nxt;
                end else begin
                    m_tlast_o <= 1'b0;
                end
            end

            // A word accepted during TAIL belongs to the next frame and seeds its count.
            if (tail_done) begin
                seq    <= seq + CBITS'(1);
                wcount <= CBITS'(full_nxt);
            end else if (accept && (state != TAIL) && (wcount != {CBITS{1'b1}})) begin
                wcount <= wcount + CBITS'(1);
            end
        end
    end

endmodule
